// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
//   Writeback stage of the NPC core. Arbitrates finished results from the
//   execute unit (EXU) and the load/store unit (LSU) onto the single write
//   port of the general register file. It also extends load data and counts
//   retired instructions.
//
//   All outputs are registered on posedge clk, so they are stable when the
//   register file samples them on the falling edge.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   exu_valid/exu_ready           EXU result handshake
//   exu_wen, exu_rd, exu_data     EXU result payload
//   lsu_valid/lsu_ready           LSU result handshake (loads and stores)
//   lsu_wen, lsu_rd, lsu_data     LSU payload (lsu_data = raw aligned dword)
//   lsu_size, lsu_unsigned,       load field size (0=b,1=h,2=w,3=d),
//   lsu_offset                    zero/sign extension select, byte offset
//   rf_wen, rf_rd, rf_wdata       register file write port
//   commit_valid                  one-cycle pulse per retired instruction
//   instret                       retired-instruction counter
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic                  exu_wen,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,

  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic                  lsu_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic [1:0]            lsu_size,
  input  logic                  lsu_unsigned,
  input  logic [2:0]            lsu_offset,

  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit_valid,
  output logic [63:0]           instret
);

  // One-entry hold buffer for the EXU result that loses to the LSU.
  logic                  hold_valid_q, hold_valid_d;
  logic                  hold_wen_q,   hold_wen_d;
  logic [ADDR_WIDTH-1:0] hold_rd_q,    hold_rd_d;
  logic [DATA_WIDTH-1:0] hold_data_q,  hold_data_d;

  // Output registers.
  logic                  rf_wen_q,       rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q,        rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q,     rf_wdata_d;
  logic                  commit_valid_q, commit_valid_d;
  logic [63:0]           instret_q,      instret_d;

  logic                  exu_fire, lsu_fire;
  logic                  issue_valid;
  logic                  issue_wen;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic [DATA_WIDTH-1:0] issue_data;

  // Ready depends on state only; a full hold buffer must drain before
  // anything new is accepted, which keeps program order per channel pair.
  assign exu_ready = !hold_valid_q;
  assign lsu_ready = !hold_valid_q;
  assign exu_fire  = exu_valid && exu_ready;
  assign lsu_fire  = lsu_valid && lsu_ready;

  // ---------------------------------------------------------------------
  // Load extension: shift the addressed bytes down (zero fill), pick the
  // field, then sign- or zero-extend. Bytes shifted past the top read as 0.
  // ---------------------------------------------------------------------
  logic [5:0]            load_shamt;
  logic [DATA_WIDTH-1:0] load_shifted;
  logic [DATA_WIDTH-1:0] load_ext;

  assign load_shamt   = {lsu_offset, 3'b000};
  assign load_shifted = lsu_data >> load_shamt;

  always_comb begin
    load_ext = load_shifted;
    unique case (lsu_size)
      2'd0: load_ext = {{(DATA_WIDTH-8){load_shifted[7] & ~lsu_unsigned}},
                        load_shifted[7:0]};
      2'd1: load_ext = {{(DATA_WIDTH-16){load_shifted[15] & ~lsu_unsigned}},
                        load_shifted[15:0]};
      2'd2: load_ext = {{(DATA_WIDTH-32){load_shifted[31] & ~lsu_unsigned}},
                        load_shifted[31:0]};
      2'd3: load_ext = load_shifted;
    endcase
  end

  // ---------------------------------------------------------------------
  // Issue selection: hold buffer, then LSU, then EXU. When both channels
  // fire together the EXU result parks in the hold buffer.
  // ---------------------------------------------------------------------
  always_comb begin
    issue_valid = 1'b0;
    issue_wen   = 1'b0;
    issue_rd    = rf_rd_q;
    issue_data  = rf_wdata_q;
    hold_valid_d = hold_valid_q;
    hold_wen_d   = hold_wen_q;
    hold_rd_d    = hold_rd_q;
    hold_data_d  = hold_data_q;

    if (hold_valid_q) begin
      issue_valid  = 1'b1;
      issue_wen    = hold_wen_q;
      issue_rd     = hold_rd_q;
      issue_data   = hold_data_q;
      hold_valid_d = 1'b0;
    end else if (lsu_fire) begin
      issue_valid = 1'b1;
      issue_wen   = lsu_wen;
      issue_rd    = lsu_rd;
      issue_data  = load_ext;
      if (exu_fire) begin
        hold_valid_d = 1'b1;
        hold_wen_d   = exu_wen;
        hold_rd_d    = exu_rd;
        hold_data_d  = exu_data;
      end
    end else if (exu_fire) begin
      issue_valid = 1'b1;
      issue_wen   = exu_wen;
      issue_rd    = exu_rd;
      issue_data  = exu_data;
    end
  end

  // Writes to x0 retire but never reach the register file.
  assign rf_wen_d       = issue_valid && issue_wen && (issue_rd != '0);
  assign rf_rd_d        = issue_rd;
  assign rf_wdata_d     = issue_data;
  assign commit_valid_d = issue_valid;
  // The commit shown this cycle is counted at the next edge.
  assign instret_d      = instret_q + 64'(commit_valid_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q   <= 1'b0;
      hold_wen_q     <= 1'b0;
      hold_rd_q      <= '0;
      hold_data_q    <= '0;
      rf_wen_q       <= 1'b0;
      rf_rd_q        <= '0;
      rf_wdata_q     <= '0;
      commit_valid_q <= 1'b0;
      instret_q      <= '0;
    end else begin
      hold_valid_q   <= hold_valid_d;
      hold_wen_q     <= hold_wen_d;
      hold_rd_q      <= hold_rd_d;
      hold_data_q    <= hold_data_d;
      rf_wen_q       <= rf_wen_d;
      rf_rd_q        <= rf_rd_d;
      rf_wdata_q     <= rf_wdata_d;
      commit_valid_q <= commit_valid_d;
      instret_q      <= instret_d;
    end
  end

  assign rf_wen       = rf_wen_q;
  assign rf_rd        = rf_rd_q;
  assign rf_wdata     = rf_wdata_q;
  assign commit_valid = commit_valid_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
//   Self-checking bench for wb_stage. A queue-based reference model tracks
//   pending results; directed scenarios pin the model with literal values,
//   then a randomized phase compares every cycle against the model.
// ---------------------------------------------------------------------------
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        exu_valid, exu_ready, exu_wen;
  logic [4:0]  exu_rd;
  logic [63:0] exu_data;
  logic        lsu_valid, lsu_ready, lsu_wen;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;
  logic [2:0]  lsu_offset;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [63:0] rf_wdata;
  logic        commit_valid;
  logic [63:0] instret;

  wb_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen),
    .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wen(lsu_wen),
    .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned), .lsu_offset(lsu_offset),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .commit_valid(commit_valid), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    bit        wen;
    bit [4:0]  rd;
    bit [63:0] data;
  } res_t;

  res_t        pend[$];
  logic        exp_commit;
  logic        exp_wen;
  logic [4:0]  exp_rd;
  logic [63:0] exp_wdata;
  logic [63:0] exp_instret;
  bit          m_exu_fire, m_lsu_fire;

  function automatic logic [63:0] ref_load(logic [63:0] d, int off, int size, bit uns);
    logic [63:0] s;
    logic [63:0] mask;
    int nb;
    s  = d >> (off * 8);
    nb = 8 << size;
    if (size == 3) return s;
    mask = (64'd1 << nb) - 64'd1;
    s = s & mask;
    if (!uns && s[nb-1]) s = s | ~mask;
    return s;
  endfunction

  function automatic void model_reset();
    pend.delete();
    exp_commit  = 1'b0;
    exp_wen     = 1'b0;
    exp_rd      = '0;
    exp_wdata   = '0;
    exp_instret = '0;
    m_exu_fire  = 1'b0;
    m_lsu_fire  = 1'b0;
  endfunction

  // Called right after each posedge with the inputs that were stable there.
  function automatic void model_edge();
    res_t r;
    bit   rdy;
    exp_instret = exp_instret + 64'(exp_commit);
    rdy = (pend.size() == 0);
    m_lsu_fire = lsu_valid && rdy;
    m_exu_fire = exu_valid && rdy;
    if (m_lsu_fire) begin
      r.wen  = lsu_wen;
      r.rd   = lsu_rd;
      r.data = ref_load(lsu_data, int'(lsu_offset), int'(lsu_size), lsu_unsigned);
      pend.push_back(r);
    end
    if (m_exu_fire) begin
      r.wen  = exu_wen;
      r.rd   = exu_rd;
      r.data = exu_data;
      pend.push_back(r);
    end
    if (pend.size() > 0) begin
      r = pend.pop_front();
      exp_commit = 1'b1;
      exp_wen    = r.wen && (r.rd != 0);
      exp_rd     = r.rd;
      exp_wdata  = r.data;
    end else begin
      exp_commit = 1'b0;
      exp_wen    = 1'b0;
    end
  endfunction

  function automatic void compare_all();
    bit rdy;
    rdy = (pend.size() == 0);
    chk("commit_valid", 64'(commit_valid), 64'(exp_commit));
    chk("rf_wen",       64'(rf_wen),       64'(exp_wen));
    chk("rf_rd",        64'(rf_rd),        64'(exp_rd));
    chk("rf_wdata",     rf_wdata,          exp_wdata);
    chk("instret",      instret,           exp_instret);
    chk("exu_ready",    64'(exu_ready),    64'(rdy));
    chk("lsu_ready",    64'(lsu_ready),    64'(rdy));
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_inputs();
    exu_valid = 0; exu_wen = 0; exu_rd = '0; exu_data = '0;
    lsu_valid = 0; lsu_wen = 0; lsu_rd = '0; lsu_data = '0;
    lsu_size = '0; lsu_unsigned = 0; lsu_offset = '0;
  endtask

  task automatic rand_exu();
    exu_valid = ($urandom_range(0, 9) < 6);
    exu_wen   = 1'($urandom_range(0, 3) != 0);
    exu_rd    = 5'($urandom_range(0, 31));
    exu_data  = {$urandom, $urandom};
  endtask

  task automatic rand_lsu();
    lsu_valid    = ($urandom_range(0, 9) < 6);
    lsu_wen      = 1'($urandom_range(0, 3) != 0);
    lsu_rd       = 5'($urandom_range(0, 31));
    lsu_data     = {$urandom, $urandom};
    lsu_size     = 2'($urandom_range(0, 3));
    lsu_unsigned = 1'($urandom_range(0, 1));
    lsu_offset   = 3'($urandom_range(0, 7));
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_rf_wen",   64'(rf_wen),       64'd0);
    chk("rst_rf_rd",    64'(rf_rd),        64'd0);
    chk("rst_rf_wdata", rf_wdata,          64'd0);
    chk("rst_commit",   64'(commit_valid), 64'd0);
    chk("rst_instret",  instret,           64'd0);
    chk("rst_exu_rdy",  64'(exu_ready),    64'd1);
    chk("rst_lsu_rdy",  64'(lsu_ready),    64'd1);
    #2 rst_n = 1'b1;
    cycle();
    chk("idle_instret", instret,           64'd0);
    chk("idle_exu_rdy", 64'(exu_ready),    64'd1);

    // EXU only.
    exu_valid = 1; exu_wen = 1; exu_rd = 5'd5; exu_data = 64'h1234;
    cycle();
    chk("exu_rf_wen",   64'(rf_wen),       64'd1);
    chk("exu_rf_rd",    64'(rf_rd),        64'd5);
    chk("exu_rf_wdata", rf_wdata,          64'h1234);
    chk("exu_commit",   64'(commit_valid), 64'd1);
    clear_inputs();
    cycle();
    chk("exu_instret",  instret,           64'd1);
    chk("exu_commit_0", 64'(commit_valid), 64'd0);

    // LSU and EXU together.
    lsu_valid = 1; lsu_wen = 1; lsu_rd = 5'd3; lsu_data = 64'h00AA; lsu_size = 2'd3;
    exu_valid = 1; exu_wen = 1; exu_rd = 5'd4; exu_data = 64'd7;
    cycle();
    chk("pair_rd1",     64'(rf_rd),        64'd3);
    chk("pair_data1",   rf_wdata,          64'h00AA);
    chk("pair_exu_rdy", 64'(exu_ready),    64'd0);
    chk("pair_lsu_rdy", 64'(lsu_ready),    64'd0);
    clear_inputs();
    cycle();
    chk("pair_rd2",     64'(rf_rd),        64'd4);
    chk("pair_data2",   rf_wdata,          64'd7);
    chk("pair_wen2",    64'(rf_wen),       64'd1);

    // Half-word load at offset 2, signed then unsigned.
    lsu_valid = 1; lsu_wen = 1; lsu_rd = 5'd6; lsu_data = 64'h0000_0000_80FF_0000;
    lsu_offset = 3'd2; lsu_size = 2'd1; lsu_unsigned = 0;
    cycle();
    chk("ld_signed",    rf_wdata,          64'hFFFF_FFFF_FFFF_80FF);
    lsu_unsigned = 1;
    cycle();
    chk("ld_unsigned",  rf_wdata,          64'h0000_0000_0000_80FF);

    // x0 write and a store: retire without writing.
    clear_inputs();
    exu_valid = 1; exu_wen = 1; exu_rd = 5'd0; exu_data = 64'hDEAD;
    cycle();
    chk("x0_rf_wen",    64'(rf_wen),       64'd0);
    chk("x0_commit",    64'(commit_valid), 64'd1);
    clear_inputs();
    lsu_valid = 1; lsu_wen = 0; lsu_rd = 5'd9; lsu_data = 64'h55; lsu_size = 2'd3;
    cycle();
    chk("st_rf_wen",    64'(rf_wen),       64'd0);
    chk("st_commit",    64'(commit_valid), 64'd1);
    clear_inputs();
    cycle();
    chk("st_instret",   instret,           64'd7);
    chk("idle_rd_hold", 64'(rf_rd),        64'd9);

    // Reset while the hold buffer is full.
    lsu_valid = 1; lsu_wen = 1; lsu_rd = 5'd10; lsu_data = 64'h1; lsu_size = 2'd3;
    exu_valid = 1; exu_wen = 1; exu_rd = 5'd11; exu_data = 64'h2;
    cycle();
    chk("hf_exu_rdy",   64'(exu_ready),    64'd0);
    clear_inputs();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mr_exu_rdy",   64'(exu_ready),    64'd1);
    chk("mr_lsu_rdy",   64'(lsu_ready),    64'd1);
    chk("mr_rf_wen",    64'(rf_wen),       64'd0);
    chk("mr_commit",    64'(commit_valid), 64'd0);
    chk("mr_instret",   instret,           64'd0);
    #1 rst_n = 1'b1;
    cycle();
    chk("mr_no_write",  64'(rf_wen),       64'd0);
    chk("mr_no_commit", 64'(commit_valid), 64'd0);

    // Randomized phase; stalled channels keep their payload.
    rand_exu();
    rand_lsu();
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (!(exu_valid && !m_exu_fire)) rand_exu();
      if (!(lsu_valid && !m_lsu_fire)) rand_lsu();
    end
    clear_inputs();
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the NPC core, directly upstream of the general register file. It takes finished results from the execute unit and the load/store unit over two valid/ready channels and arbitrates them onto the register file's single write port (`wen`/`rd`/`wdata`). It sign- or zero-extends load data and counts retired instructions. Its outputs are registered on the rising edge, so they are stable when the register file samples them on the falling edge.

## Interface
Parameters:
- `ADDR_WIDTH`, 5: register index width
- `DATA_WIDTH`, 64: register and data width

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `rst_n`  in  1  reset, asynchronous and active-low
- `exu_valid`  in  1  EXU result valid
- `exu_ready`  out  1  stage accepts an EXU result
- `exu_wen`  in  1  result writes a register
- `exu_rd`  in  ADDR_WIDTH  destination index
- `exu_data`  in  DATA_WIDTH  result value
- `lsu_valid`  in  1  LSU result valid (loads and stores)
- `lsu_ready`  out  1  stage accepts an LSU result
- `lsu_wen`  in  1  1 for loads, 0 for stores
- `lsu_rd`  in  ADDR_WIDTH  destination index
- `lsu_data`  in  DATA_WIDTH  raw aligned doubleword from memory
- `lsu_size`  in  2  0=byte, 1=half, 2=word, 3=dword
- `lsu_unsigned`  in  1  zero-extend when 1, sign-extend when 0
- `lsu_offset`  in  3  byte offset of the access inside the doubleword
- `rf_wen`  out  1  register file write enable
- `rf_rd`  out  ADDR_WIDTH  register file write index
- `rf_wdata`  out  DATA_WIDTH  register file write data
- `commit_valid`  out  1  one-cycle pulse per retired instruction
- `instret`  out  64  retired-instruction counter

## Operation
- State: output register (`rf_*`, `commit_valid`), one-entry EXU hold buffer (`hold_valid`, wen, rd, data), and the `instret` counter.
- Readiness:
  - `exu_ready = lsu_ready = !hold_valid`.
  - Both are combinational from state only, with no dependence on the valid inputs.
- Issue priority each cycle:
  1. Hold buffer.
  2. Accepted LSU.
  3. Accepted EXU.
- Both channels fire with the hold buffer empty: the LSU result issues, and the EXU result is written into the hold buffer. The hold buffer issues next cycle; both readies are low that cycle.
- Only EXU fires: it issues directly, and the hold buffer is untouched.
- Issued result:
  - `commit_valid`=1.
  - `rf_wen` = wen && (rd != 0); writes to x0 are suppressed but still retire.
  - `rf_rd` = rd.
  - `rf_wdata` = data (extended data for LSU).
- No issue in a cycle: `commit_valid`=0 and `rf_wen`=0. `rf_rd`/`rf_wdata` hold their last values.
- Load extension:
  - shifted = `lsu_data >> (lsu_offset*8)`, zero-filled.
  - Take the low 8/16/32/64 bits according to `lsu_size`.
  - Sign-extend from the top bit of the field when `lsu_unsigned`=0, else zero-extend.
  - `lsu_size`=3 ignores `lsu_unsigned`.
  - A misaligned offset is not an error; bits shifted past bit 63 read as 0.
- Stores (`lsu_wen`=0) retire with `rf_wen`=0.
- `instret`: increments by 1 on each cycle where `commit_valid` is set next edge, i.e. on each issue. It wraps from 2^64-1 to 0.

## Timing
- Reset (`rst_n`=0, asynchronous): `rf_wen`=0, `rf_rd`=0, `rf_wdata`=0, `commit_valid`=0, `instret`=0, `hold_valid`=0.
  - `exu_ready` and `lsu_ready` read 1 during and after reset.
  - Reset mid-operation discards the hold buffer and the pending output.
- Latency:
  - A result accepted at posedge N appears on `rf_*` in cycle N+1 and is written by the register file at the falling edge of cycle N+1.
  - A held EXU result appears in cycle N+2.
- Throughput: one result per cycle. A simultaneous LSU+EXU pair takes 2 cycles, with no accepts in the second.
- Handshake: a transfer occurs iff valid && ready at posedge. Inputs are sampled only on a transfer. Upstream holds its payload while valid && !ready.
- `instret` is visible one cycle after the instruction's `commit_valid` cycle, i.e. it counts the commit of cycle N at edge N+1.
- A back-to-back write to the same `rd` from hold and then from a new input is issued in that order (program order preserved).

## Test plan
- Reset then idle → all `rf_*`=0, `commit_valid`=0, `instret`=0, both readies 1.
- EXU only, rd=5, data=0x1234, wen=1 → next cycle `rf_wen`=1, `rf_rd`=5, `rf_wdata`=0x1234, `commit_valid`=1; one cycle later `instret`=1.
- LSU and EXU valid in the same cycle (LSU rd=3; EXU rd=4, data=7) → cycle+1 writes x3; readies low; cycle+2 writes x4=7.
- Load with `lsu_data`=0x0000_0000_80FF_0000, offset=2, size=1:
  - signed → `rf_wdata`=0xFFFF_FFFF_FFFF_80FF
  - unsigned → `rf_wdata`=0x80FF
- EXU to rd=0 with wen=1, and an LSU store → `rf_wen`=0 both times, `commit_valid`=1 both times, `instret` +2.
- Assert `rst_n`=0 while the hold buffer is full → hold discarded immediately; readies 1; no write after release.
